fright_mode_ctrl: RTL
=====================

Name: fright_mode_ctrl

Overview:
- Runtime consumer of the per-level fright parameters (fright_time in seconds, fright_flashes).
- Starts when a power pellet is eaten; runs the blue and flashing ghost phases using a 60 Hz frame tick generated internally from the system clock.
- Tracks the ghost-eat chain index for scoring (200/400/800/1600).
- Sits between the level parameter table and the ghost FSMs, speed pacers and score logic.

Parameters:
- FRAME_DIV, 833333: clock cycles per frame tick (50 MHz / 60).
- FPS, 60: frame ticks per fright second.
- FLASH_HALF, 14: frames per half flash (white or blue); one flash = 2*FLASH_HALF frames.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- level_start, in, 1: synchronous clear to idle.
- pause, in, 1: freezes the prescaler and all counters.
- pellet_eaten, in, 1: one-cycle pulse, power pellet consumed.
- ghost_eaten, in, 1: one-cycle pulse, frightened ghost eaten.
- fright_time, in, 4: seconds of fright, sampled on pellet_eaten.
- fright_flashes, in, 3: flash count, sampled on pellet_eaten.
- ghost_reverse, out, 1: one-cycle pulse, ghosts reverse direction.
- frightened, out, 1: fright phase active.
- flashing, out, 1: end-of-fright warning phase active.
- flash_white, out, 1: ghost colour select while flashing (1 = white).
- fright_done, out, 1: one-cycle pulse at natural expiry.
- eat_index, out, 2: next ghost score index, 0..3.

Behaviour:
- Reset (async, rst_n low): all outputs 0, remaining = 0, prescaler = 0, flash_cnt = 0, state IDLE.
- Prescaler counts 0..FRAME_DIV-1.
  - frame_tick fires on the wrap.
  - The prescaler resets to 0 on every pellet_eaten, so the first tick comes FRAME_DIV cycles after the pellet.
  - It holds while pause = 1.
- States: IDLE and FRIGHT. flashing is derived, not a separate state.
- pellet_eaten (any state), registered, visible the next cycle:
  - ghost_reverse pulses 1 cycle; eat_index <= 0; flash_cnt <= 0.
  - remaining <= fright_time*FPS (10 bits, max 900); flash_frames <= fright_flashes*2*FLASH_HALF (8 bits, max 196).
  - If fright_time = 0: state IDLE, frightened = 0. Reverse still occurs and no fright_done pulse is issued.
  - Otherwise: state FRIGHT, frightened = 1.
- In FRIGHT, on each frame_tick with pause = 0:
  - remaining decrements.
  - On the tick where remaining goes 1 -> 0: state IDLE, frightened = 0, flashing = 0, flash_white = 0, fright_done = 1 for exactly one cycle.
- flashing = frightened AND (remaining <= flash_frames), using the registered remaining.
  - flash_frames >= initial remaining means flashing from the first cycle of fright.
  - flash_frames = 0 means never flashing.
- flash_cnt counts frame ticks while flashing, wrapping at 2*FLASH_HALF-1 -> 0.
  - flash_white = flashing AND (flash_cnt < FLASH_HALF); it starts white.
  - flash_cnt is cleared when not flashing.
- eat_index increments on ghost_eaten while frightened, saturating at 3. ghost_eaten outside fright is ignored.
- Simultaneous events:
  - pellet_eaten with expiry tick: pellet wins (restart, no fright_done).
  - pellet_eaten with ghost_eaten: eat_index = 0.
  - level_start with anything: level_start wins. Clear to the reset values, no pulses.
- pause = 1 holds all state and outputs except pulses. pellet_eaten and level_start are still honoured during pause.

Test Plan:
- FRAME_DIV=4, fright_time=1, fright_flashes=1, pellet at cycle T:
  - ghost_reverse at T+1; frightened T+1..T+240.
  - flashing starts when remaining=28; flash_white 1 for 14 ticks then 0 for 14.
  - fright_done 1-cycle pulse, then all outputs 0.
- fright_time=0, pellet -> ghost_reverse pulse only; frightened, flashing and fright_done stay 0.
- fright_time=1, fright_flashes=5 (140 < 60? no, 140 >= 60) -> flashing=1 from the first fright cycle.
- During fright, 5 ghost_eaten pulses -> eat_index 1,2,3,3,3.
  - Second pellet mid-fright -> eat_index 0, remaining reloaded, no fright_done.
- pause held 100 cycles mid-fright -> remaining, flash_cnt and prescaler unchanged; expiry delayed by exactly 100 cycles.
- rst_n low mid-flash (asynchronous, no clock edge) -> all outputs 0 immediately.
  - Same case with level_start instead -> outputs 0 the next cycle, no fright_done.

Source files
------------

// File: rtl/fright_mode_ctrl.sv
// fright_mode_ctrl
//   Runs the frightened (blue) and flashing ghost phases after a power pellet.
//   A free-running prescaler derives a frame tick from the system clock; a
//   frame-granular countdown drives the fright/flash phases, and a small
//   saturating counter tracks the ghost-eat chain for scoring.
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   level_start      : synchronous clear to idle (wins over everything)
//   pause            : freezes prescaler and all counters
//   pellet_eaten     : 1-cycle pulse, starts/restarts fright
//   ghost_eaten      : 1-cycle pulse, advances eat_index while frightened
//   fright_time      : fright seconds, sampled on pellet_eaten
//   fright_flashes   : flash count, sampled on pellet_eaten
//   ghost_reverse    : 1-cycle pulse after every pellet
//   frightened       : fright phase active
//   flashing         : end-of-fright warning phase active
//   flash_white      : colour select while flashing (1 = white)
//   fright_done      : 1-cycle pulse at natural expiry
//   eat_index        : next ghost score index 0..3
module fright_mode_ctrl #(
    parameter int FRAME_DIV  = 833333,
    parameter int FPS        = 60,
    parameter int FLASH_HALF = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       level_start,
    input  logic       pause,
    input  logic       pellet_eaten,
    input  logic       ghost_eaten,
    input  logic [3:0] fright_time,
    input  logic [2:0] fright_flashes,
    output logic       ghost_reverse,
    output logic       frightened,
    output logic       flashing,
    output logic       flash_white,
    output logic       fright_done,
    output logic [1:0] eat_index
);
    localparam int PW  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int FCW = (2 * FLASH_HALF > 1) ? $clog2(2 * FLASH_HALF) : 1;

    localparam logic [PW-1:0]  PRESC_MAX  = PW'(FRAME_DIV - 1);
    localparam logic [FCW-1:0] FLASH_MAX  = FCW'(2 * FLASH_HALF - 1);
    localparam logic [FCW-1:0] FLASH_HLF  = FCW'(FLASH_HALF);
    localparam logic [9:0]     FPS_V      = 10'(FPS);
    localparam logic [7:0]     FLASH_LEN  = 8'(2 * FLASH_HALF);

    typedef enum logic {IDLE = 1'b0, FRIGHT = 1'b1} state_t;

    state_t         state, state_nxt;
    logic [PW-1:0]  presc, presc_nxt;
    logic [9:0]     remaining, remaining_nxt;
    logic [7:0]     flash_frames, flash_frames_nxt;
    logic [FCW-1:0] flash_cnt, flash_cnt_nxt;
    logic [1:0]     eat_nxt;
    logic           rev_nxt, done_nxt;
    logic           frame_tick;

    // Tick is gated by pause so every frame-based counter freezes with it.
    assign frame_tick  = !pause && (presc == PRESC_MAX);

    assign frightened  = (state == FRIGHT);
    assign flashing    = frightened && (remaining <= {2'b00, flash_frames});
    assign flash_white = flashing && (flash_cnt < FLASH_HLF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            presc         <= '0;
            remaining     <= '0;
            flash_frames  <= '0;
            flash_cnt     <= '0;
            eat_index     <= '0;
            ghost_reverse <= 1'b0;
            fright_done   <= 1'b0;
        end else begin
            state         <= state_nxt;
            presc         <= presc_nxt;
            remaining     <= remaining_nxt;
            flash_frames  <= flash_frames_nxt;
            flash_cnt     <= flash_cnt_nxt;
            eat_index     <= eat_nxt;
            ghost_reverse <= rev_nxt;
            fright_done   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        presc_nxt        = presc;
        remaining_nxt    = remaining;
        flash_frames_nxt = flash_frames;
        flash_cnt_nxt    = flash_cnt;
        eat_nxt          = eat_index;
        rev_nxt          = 1'b0;
        done_nxt         = 1'b0;

        if (level_start) begin
            state_nxt        = IDLE;
            presc_nxt        = '0;
            remaining_nxt    = '0;
            flash_frames_nxt = '0;
            flash_cnt_nxt    = '0;
            eat_nxt          = '0;
        end else if (pellet_eaten) begin
            // Restart wins over a coincident expiry tick or ghost eat.
            presc_nxt        = '0;
            rev_nxt          = 1'b1;
            eat_nxt          = '0;
            flash_cnt_nxt    = '0;
            remaining_nxt    = 10'(fright_time) * FPS_V;
            flash_frames_nxt = 8'(fright_flashes) * FLASH_LEN;
            state_nxt        = (fright_time == 4'd0) ? IDLE : FRIGHT;
        end else begin
            if (!pause)
                presc_nxt = (presc == PRESC_MAX) ? '0 : presc + 1'b1;

            if (frightened && frame_tick) begin
                remaining_nxt = remaining - 10'd1;
                if (remaining == 10'd1) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end

            if (!flashing)
                flash_cnt_nxt = '0;
            else if (frame_tick)
                flash_cnt_nxt = (flash_cnt == FLASH_MAX) ? '0 : flash_cnt + 1'b1;

            if (ghost_eaten && frightened && !pause && (eat_index != 2'd3))
                eat_nxt = eat_index + 2'd1;
        end
    end
endmodule
